// File: rtl/spi_wb_pkg.sv
// Shared constants for the SPI-to-Wishbone bridge: command bytes,
// response bytes and the bridge FSM state encoding.
package spi_wb_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ     = 8'h02;

    localparam logic [7:0] RESP_OK      = 8'h00;
    localparam logic [7:0] RESP_TIMEOUT = 8'hFF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR_H = 3'd1;
    localparam logic [2:0] ST_ADDR_L = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

endpackage

// File: rtl/spi_wb_bridge.sv
// SPI byte stream to Wishbone classic master bridge.
// Frame: command byte, address high, address low, [write data].
// One Wishbone cycle per frame; a single response byte is returned.
//
// state   | meaning
// IDLE    | waiting for a command byte (0x01 write, 0x02 read)
// ADDR_H  | waiting for address bits 15:8
// ADDR_L  | waiting for address bits 7:0
// DATA    | waiting for the write data byte
// WB      | Wishbone cycle in flight, wait counter running
// RESP    | response byte offered to the SPI slave
module spi_wb_bridge
    import spi_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_idle,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [7:0]            wb_dat_o,
    input  logic [7:0]            wb_dat_i,
    input  logic                  wb_ack_i,
    output logic                  busy
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic [7:0]  resp_q, resp_d;
    logic [7:0]  cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    // Next-state and datapath: decode bytes, run the bus cycle, hand off response
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        resp_d  = resp_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                    we_d    = (rx_data == CMD_WRITE);
                    state_d = ST_ADDR_H;
                end
            end
            ST_ADDR_H: begin
                // chip select release wins over a byte arriving in the same cycle
                if (cs_idle) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    addr_d[15:8] = rx_data;
                    state_d      = ST_ADDR_L;
                end
            end
            ST_ADDR_L: begin
                if (cs_idle) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    addr_d[7:0] = rx_data;
                    if (we_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_WB;
                        cyc_d   = 1'b1;
                        cnt_d   = 8'd0;
                    end
                end
            end
            ST_DATA: begin
                if (cs_idle) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    data_d  = rx_data;
                    state_d = ST_WB;
                    cyc_d   = 1'b1;
                    cnt_d   = 8'd0;
                end
            end
            ST_WB: begin
                // an ack on the final wait cycle still counts as a normal completion
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    resp_d  = we_q ? RESP_OK : wb_dat_i;
                    state_d = ST_RESP;
                end else if (cnt_inc == WAIT_LIMIT) begin
                    cnt_d   = cnt_inc;
                    cyc_d   = 1'b0;
                    resp_d  = RESP_TIMEOUT;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            data_q  <= 8'd0;
            cnt_q   <= 8'd0;
            cyc_q   <= 1'b0;
            resp_q  <= RESP_TIMEOUT;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            resp_q  <= resp_d;
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q & we_q;
    assign wb_adr_o = ADDR_WIDTH'(addr_q);
    assign wb_dat_o = data_q;
    assign tx_data  = resp_q;
    assign tx_valid = (state_q == ST_RESP);
    assign busy     = (state_q != ST_IDLE);
    assign rx_ready = (state_q == ST_IDLE) || (state_q == ST_ADDR_H) ||
                      (state_q == ST_ADDR_L) || (state_q == ST_DATA);

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Self-checking bench for spi_wb_bridge: directed frames from the block's
// example list plus randomized frames checked against a transaction model.
module tb_spi_wb_bridge;

    localparam int AW = 16;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs_idle = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [7:0]    wb_dat_o;
    logic [7:0]    wb_dat_i = 8'h00;
    logic          wb_ack_i = 1'b0;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int starts_wr = 0;
    int starts_rd = 0;
    logic cyc_prev = 1'b0;

    spi_wb_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cs_idle(cs_idle),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count bus cycle starts, split by direction
    always @(posedge clk) begin
        cyc_prev <= wb_cyc_o;
        if (wb_cyc_o && !cyc_prev) begin
            if (wb_we_o) starts_wr <= starts_wr + 1;
            else         starts_rd <= starts_rd + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // One full frame against a transaction-level expectation.
    // ack_at: cyc cycle (1-based) on which ack is raised; 0 means never.
    task automatic run_txn(input logic is_wr, input logic [15:0] addr,
                           input logic [7:0] wdat, input logic [7:0] rdat,
                           input int ack_at, input int hold, input logic poke);
        logic [7:0] exp_resp;
        int exp_len;
        int n;
        int wr0;
        int rd0;
        logic acked;
        acked    = (ack_at >= 1) && (ack_at <= TO);
        exp_len  = acked ? ack_at : TO;
        exp_resp = !acked ? 8'hFF : (is_wr ? 8'h00 : rdat);
        wr0 = starts_wr;
        rd0 = starts_rd;

        send_byte(is_wr ? 8'h01 : 8'h02);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        if (is_wr) send_byte(wdat);

        n = 0;
        while (wb_cyc_o !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wb_cyc_o !== 1'b1 || n != 0) begin
            failures++;
            $display("FAIL cyc_start: cyc=%b after %0d extra cycles, required cyc=1 right after last byte", wb_cyc_o, n);
        end
        checks++;
        if (wb_we_o !== is_wr || wb_adr_o !== addr || (is_wr && wb_dat_o !== wdat)) begin
            failures++;
            $display("FAIL bus_req: we=%b adr=%h dat=%h, required we=%b adr=%h dat=%h",
                     wb_we_o, wb_adr_o, wb_dat_o, is_wr, addr, wdat);
        end

        n = 0;
        while (wb_cyc_o === 1'b1 && n < 400) begin
            n++;
            checks++;
            if (wb_stb_o !== 1'b1 || wb_adr_o !== addr || wb_we_o !== is_wr ||
                (is_wr && wb_dat_o !== wdat) || rx_ready !== 1'b0 || busy !== 1'b1 || tx_valid !== 1'b0) begin
                failures++;
                $display("FAIL bus_hold: cycle %0d stb=%b adr=%h we=%b rx_ready=%b busy=%b tx_valid=%b, required 1/%h/%b/0/1/0",
                         n, wb_stb_o, wb_adr_o, wb_we_o, rx_ready, busy, tx_valid, addr, is_wr);
            end
            if (n == ack_at) begin
                wb_ack_i = 1'b1;
                wb_dat_i = rdat;
            end else begin
                wb_ack_i = 1'b0;
                wb_dat_i = 8'($urandom);
            end
            @(negedge clk);
        end
        wb_ack_i = 1'b0;

        checks++;
        if (n != exp_len) begin
            failures++;
            $display("FAIL cyc_len: cyc high %0d cycles, required %0d", n, exp_len);
        end
        checks++;
        if ((starts_wr - wr0) != (is_wr ? 1 : 0) || (starts_rd - rd0) != (is_wr ? 0 : 1)) begin
            failures++;
            $display("FAIL cyc_count: writes=%0d reads=%0d, required writes=%0d reads=%0d",
                     starts_wr - wr0, starts_rd - rd0, is_wr ? 1 : 0, is_wr ? 0 : 1);
        end
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp_resp || wb_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL resp: tx_valid=%b tx_data=%h stb=%b, required 1/%h/0", tx_valid, tx_data, wb_stb_o, exp_resp);
        end

        tx_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            rx_data  = 8'h01;
            rx_valid = poke && (i == 1);
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_resp || rx_ready !== 1'b0) begin
                failures++;
                $display("FAIL resp_hold: cycle %0d tx_valid=%b tx_data=%h rx_ready=%b, required 1/%h/0",
                         i, tx_valid, tx_data, rx_ready, exp_resp);
            end
        end
        rx_valid = 1'b0;

        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL resp_done: tx_valid=%b busy=%b rx_ready=%b, required 0/0/1", tx_valid, busy, rx_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0 || tx_valid !== 1'b0 ||
            busy !== 1'b0 || rx_ready !== 1'b1 || tx_data !== 8'hFF || wb_adr_o !== 16'h0 || wb_dat_o !== 8'h00) begin
            failures++;
            $display("FAIL reset: cyc=%b stb=%b we=%b txv=%b busy=%b rxr=%b txd=%h adr=%h dat=%h, required 0/0/0/0/0/1/ff/0000/00",
                     wb_cyc_o, wb_stb_o, wb_we_o, tx_valid, busy, rx_ready, tx_data, wb_adr_o, wb_dat_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        run_txn(1'b1, 16'h1234, 8'h5A, 8'h00, 3, 4, 1'b0);
    endtask

    task automatic test_read();
        run_txn(1'b0, 16'h0010, 8'h00, 8'hC3, 2, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 16'h0020, 8'h00, 8'h00, 0, 1, 1'b0);
        // ack on the very cycle the wait limit is reached is a completion
        run_txn(1'b0, 16'h0021, 8'h00, 8'h6B, TO, 0, 1'b0);
    endtask

    task automatic test_abort();
        int wr0;
        wr0 = starts_wr;
        send_byte(8'h01);
        send_byte(8'h12);
        @(negedge clk);
        cs_idle = 1'b1;
        @(negedge clk);
        cs_idle = 1'b0;
        checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle: busy=%b rx_ready=%b, required 0/1", busy, rx_ready);
        end
        run_txn(1'b0, 16'h0005, 8'h00, 8'h99, 1, 0, 1'b0);
        checks++;
        if (starts_wr != wr0) begin
            failures++;
            $display("FAIL abort_nowrite: %0d writes issued, required 0", starts_wr - wr0);
        end
        // byte and cs release together in ADDR_H: byte dropped, frame aborted
        send_byte(8'h02);
        @(negedge clk);
        rx_data  = 8'h44;
        rx_valid = 1'b1;
        cs_idle  = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        cs_idle  = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL cs_priority: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_junk_backpressure();
        send_byte(8'h7E);
        checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL junk: busy=%b rx_ready=%b, required 0/1", busy, rx_ready);
        end
        run_txn(1'b1, 16'hBEEF, 8'h11, 8'h00, 5, 10, 1'b1);
    endtask

    task automatic test_reset_in_wb();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h40);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (wb_cyc_o !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'hFF) begin
            failures++;
            $display("FAIL reset_wb: cyc=%b busy=%b tx_valid=%b tx_data=%h, required 0/0/0/ff",
                     wb_cyc_o, busy, tx_valid, tx_data);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || wb_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_wb_quiet: tx_valid=%b cyc=%b, required 0/0", tx_valid, wb_cyc_o);
        end
    endtask

    task automatic test_random();
        logic [7:0] junk;
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom);
                if (junk == 8'h01 || junk == 8'h02) junk = 8'h80;
                send_byte(junk);
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_junk: byte %h busy=%b, required 0", junk, busy);
                end
            end
            run_txn(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                    (k == 7) ? 0 : int'($urandom_range(1, 12)),
                    int'($urandom_range(0, 4)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_abort();
        test_junk_backpressure();
        test_reset_in_wb();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
